// File: rtl/piso_stream_serializer.sv
// piso_stream_serializer: parallel-in/serial-out shifter with valid/ready input, one-word holding buffer and stallable serial output
module piso_stream_serializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             word_done
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hb;
    logic [WIDTH-1:0] sr_next;
    logic [CNT_W-1:0] cnt;
    logic             hb_full;
    logic             accept;
    logic             consume;

    assign in_ready  = !hb_full;
    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : 1'b0;
    assign ser_first = ser_valid && (cnt == CNT_W'(WIDTH));
    assign ser_last  = ser_valid && (cnt == CNT_W'(1));
    assign par_out   = sr;
    assign busy      = ser_valid || hb_full;
    assign accept    = in_valid && in_ready;
    assign consume   = ser_valid && shift_en;
    assign sr_next   = MSB_FIRST ? {sr[WIDTH-2:0], ser_in} : {ser_in, sr[WIDTH-1:1]};

    // Shifter, bit counter, holding buffer and IDLE/SHIFT control; a last-bit consume reloads from hb first, then from the input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            hb        <= '0;
            hb_full   <= 1'b0;
            word_done <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            hb        <= '0;
            hb_full   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= consume && ser_last;
            if (state == IDLE) begin
                if (accept) begin
                    sr    <= in_data;
                    cnt   <= CNT_W'(WIDTH);
                    state <= SHIFT;
                end
            end else begin
                if (consume && ser_last) begin
                    if (hb_full) begin
                        sr      <= hb;
                        cnt     <= CNT_W'(WIDTH);
                        hb_full <= 1'b0;
                    end else if (accept) begin
                        sr  <= in_data;
                        cnt <= CNT_W'(WIDTH);
                    end else begin
                        sr    <= sr_next;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end else begin
                    if (consume) begin
                        sr  <= sr_next;
                        cnt <= cnt - 1'b1;
                    end
                    if (accept) begin
                        hb      <= in_data;
                        hb_full <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_piso_stream_serializer.sv
// tb_piso_stream_serializer: directed tables, corner sequences and a queue-based random reference check
module tb_piso_stream_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0, shift_en = 1'b0, ser_in = 1'b0;
    logic        in_ready, ser_out, ser_valid, ser_first, ser_last, busy, word_done;
    logic [15:0] par_out;
    logic [7:0]  d8 = '0;
    logic        v8 = 1'b0, se8 = 1'b0, si8 = 1'b0;
    logic        rdy8, so8, sv8, sf8, sl8, busy8, wd8;
    logic [7:0]  po8;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    piso_stream_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .shift_en(shift_en), .ser_in(ser_in), .ser_out(ser_out),
        .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last),
        .par_out(par_out), .busy(busy), .word_done(word_done)
    );

    piso_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .in_data(d8), .in_valid(v8),
        .in_ready(rdy8), .shift_en(se8), .ser_in(si8), .ser_out(so8),
        .ser_valid(sv8), .ser_first(sf8), .ser_last(sl8),
        .par_out(po8), .busy(busy8), .word_done(wd8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic [15:0] data;
        logic        fill;
        logic [15:0] stream;
        logic [15:0] par;
    } vec_t;

    vec_t        tbl[4];
    logic [15:0] bw[3];
    logic [47:0] exp_s;
    logic [15:0] got;
    logic [7:0]  ms;
    int          nxt, vcnt, fcnt, firstc, lastc, badbit, rdy0, b, cyc, stall, wdc, bad;
    logic [15:0] q[$];
    logic [15:0] fills, idle_par, cur;
    int          pos;
    logic        wd, acc, cons, m_valid;
    logic [22:0] m_vec;

    initial begin
        tbl[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 16'h0000};
        tbl[1] = '{16'h8001, 1'b1, 16'h8001, 16'hFFFF};
        tbl[2] = '{16'h3C96, 1'b0, 16'h3C96, 16'h0000};
        tbl[3] = '{16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF};
        bw[0] = 16'h0001; bw[1] = 16'h8000; bw[2] = 16'hFFFF;
        exp_s = {16'hFFFF, 16'h8000, 16'h0001};
        ms = 8'b1011_0100;

        #12;
        chk("reset_state", {in_ready, ser_valid, ser_out, ser_first, ser_last, busy, word_done, par_out},
            {7'b1000000, 16'h0000});
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("post_reset", {in_ready, ser_valid, busy, word_done}, 4'b1000);

        // single words, LSB first
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1; in_data = tbl[t].data; shift_en = 1'b1; ser_in = tbl[t].fill;
            @(negedge clk) in_valid = 1'b0;
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("word%0d_bit%0d", t, i), {ser_valid, ser_out, ser_first, ser_last},
                    {1'b1, tbl[t].stream[i], i == 0, i == 15});
                @(negedge clk);
            end
            chk($sformatf("word%0d_end", t), {word_done, ser_valid, busy, in_ready, par_out},
                {4'b1001, tbl[t].par});
            @(negedge clk);
        end

        // back-to-back words, gapless
        nxt = 0; vcnt = 0; fcnt = 0; firstc = -1; lastc = -1; badbit = 0; rdy0 = 0;
        shift_en = 1'b1; ser_in = 1'b0;
        for (int c = 0; c < 56; c++) begin
            if (ser_valid) begin
                if (firstc < 0) firstc = c;
                lastc = c;
                if (vcnt < 48 && ser_out !== exp_s[vcnt]) badbit++;
                if (ser_first) begin
                    fcnt++;
                    if (vcnt % 16 != 0) badbit++;
                end
                vcnt++;
            end
            if (!in_ready) rdy0++;
            in_valid = nxt < 3;
            in_data = nxt < 3 ? bw[nxt] : 16'h0;
            if (in_valid && in_ready) nxt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("btb_valid_count", vcnt, 48);
        chk("btb_first_latency", firstc, 1);
        chk("btb_no_gap", lastc - firstc, 47);
        chk("btb_first_count", fcnt, 3);
        chk("btb_bits", badbit, 0);
        chk("btb_ready_low_seen", rdy0 > 0, 1);
        chk("btb_all_accepted", nxt, 3);

        // stall at bit 7
        in_valid = 1'b1; in_data = 16'h00F0; shift_en = 1'b1; ser_in = 1'b0;
        @(negedge clk) in_valid = 1'b0;
        b = 0; cyc = 0; stall = 0; wdc = 0; got = '0;
        for (int c = 0; c < 30; c++) begin
            if (word_done) wdc++;
            if (ser_valid) begin
                cyc++;
                if (b == 7 && stall < 5) begin
                    if (stall > 0)
                        chk($sformatf("stall_hold%0d", stall), {ser_out, ser_last, par_out}, {2'b10, 16'h0001});
                    shift_en = 1'b0;
                    stall++;
                end else begin
                    shift_en = 1'b1;
                    if (b < 16) got[b] = ser_out;
                    b++;
                end
            end
            @(negedge clk);
        end
        chk("stall_bits", got, 16'h00F0);
        chk("stall_length", cyc, 21);
        chk("stall_word_done", wdc, 1);

        // MSB first, WIDTH=8
        v8 = 1'b1; d8 = 8'hB4; se8 = 1'b1; si8 = 1'b1;
        @(negedge clk) v8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("msb_bit%0d", i), {sv8, so8, sf8, sl8}, {1'b1, ms[7-i], i == 0, i == 7});
            @(negedge clk);
        end
        chk("msb_end", {wd8, sv8, po8}, {2'b10, 8'hFF});

        // clr on a cycle with accept and last-bit consume
        in_valid = 1'b1; in_data = 16'h1234; shift_en = 1'b1; ser_in = 1'b0;
        @(negedge clk) in_valid = 1'b0;
        for (int k = 0; k < 15; k++) @(negedge clk);
        chk("clr_at_last", ser_last, 1);
        in_valid = 1'b1; in_data = 16'hBEEF; clr = 1'b1;
        @(negedge clk) clr = 1'b0; in_valid = 1'b0;
        chk("clr_empty", {in_ready, busy, ser_valid, word_done, par_out}, {4'b1000, 16'h0000});
        @(negedge clk);
        chk("clr_no_done", {word_done, ser_valid}, 2'b00);

        // asynchronous reset mid-stream with buffer full
        in_valid = 1'b1; in_data = 16'hC0DE; shift_en = 1'b0;
        @(negedge clk) in_data = 16'hFACE;
        @(negedge clk) in_valid = 1'b0;
        chk("rst_hb_full", {in_ready, busy}, 2'b01);
        shift_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_async", {in_ready, ser_valid, ser_out, ser_first, ser_last, busy, word_done, par_out},
               {7'b1000000, 16'h0000});
        @(negedge clk) rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (word_done || ser_valid || !in_ready) bad++;
        end
        chk("rst_stays_empty", bad, 0);

        // random stimulus against queue model
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        q.delete(); pos = 0; fills = '0; idle_par = '0; wd = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            m_valid = q.size() > 0;
            cur = m_valid ? q[0] : 16'h0;
            m_vec = {m_valid, m_valid ? cur[pos] : 1'b0, m_valid && pos == 0, m_valid && pos == 15,
                     q.size() < 2, m_valid, wd,
                     m_valid ? 16'(({16'h0, cur} >> pos) | ({16'h0, fills} << (16 - pos))) : idle_par};
            chk($sformatf("rand%0d", c),
                {ser_valid, ser_out, ser_first, ser_last, in_ready, busy, word_done, par_out}, m_vec);
            in_valid = $urandom_range(0, 2) != 0;
            in_data = 16'($urandom);
            shift_en = $urandom_range(0, 3) != 0;
            ser_in = 1'($urandom);
            clr = $urandom_range(0, 99) == 0;
            acc = in_valid && q.size() < 2;
            cons = shift_en && m_valid;
            if (clr) begin
                q.delete(); pos = 0; fills = '0; idle_par = '0; wd = 1'b0;
            end else begin
                wd = cons && pos == 15;
                if (cons) begin
                    fills[pos] = ser_in;
                    pos++;
                    if (pos == 16) begin
                        idle_par = fills;
                        void'(q.pop_front());
                        pos = 0;
                        fills = '0;
                    end
                end
                if (acc) q.push_back(in_data);
            end
            @(negedge clk);
        end
        clr = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/piso_stream_serializer.md
Name: piso_stream_serializer

Overview:
- Parametrised parallel-in/serial-out shifter with a valid/ready word input, a one-word holding buffer and a stallable serial output.
- Feeds bit-serial consumers such as the serial multiplier and accumulator datapaths in the ELM hidden layer.
- Streams consecutive words with no idle bit-cycles between them.
- Shift direction and width are compile-time choices.

Parameters:
- WIDTH, 16, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 0, 0 = LSB first (shift right, fill at MSB); 1 = MSB first (shift left, fill at LSB).
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- clr  in  1  synchronous clear; flushes all state.
- in_data  in  WIDTH  parallel word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  consumer takes the current serial bit this cycle.
- ser_in  in  1  fill bit shifted into the vacated position.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out holds a live bit.
- ser_first  out  1  current bit is the first of its word.
- ser_last  out  1  current bit is the last of its word.
- par_out  out  WIDTH  shift-register contents.
- busy  out  1  a word is in the shifter or in the holding buffer.
- word_done  out  1  one-cycle pulse after a word's last bit is consumed.

Behaviour:
- Internal state:
  - sr, WIDTH-bit shift register.
  - cnt, bits remaining in sr.
  - hb, WIDTH-bit holding buffer, with hb_full flag.
  - FSM with states IDLE and SHIFT.
- Reset (rst=0, asynchronous):
  - sr=0, cnt=0, hb=0, hb_full=0, state=IDLE, word_done=0.
  - Resulting outputs: in_ready=1, ser_valid=0, ser_out=0, ser_first=0, ser_last=0, par_out=0, busy=0.
  - Reset mid-word discards the word in flight and any buffered word. No partial-word completion, no word_done.
- clr=1 at a clock edge has the same effect as reset, synchronously. It has priority over accept and consume in that cycle.
- Event definitions:
  - accept = in_valid & in_ready.
  - consume = ser_valid & shift_en.
- Combinational outputs:
  - in_ready = !hb_full.
  - ser_valid = (state==SHIFT).
  - ser_out = ser_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : 0.
  - ser_first = ser_valid & (cnt==WIDTH).
  - ser_last = ser_valid & (cnt==1).
  - par_out = sr.
  - busy = ser_valid | hb_full.
- IDLE state:
  - accept: sr<=in_data, cnt<=WIDTH, go to SHIFT. First bit is visible the cycle after accept.
- SHIFT state, consume with cnt>1:
  - cnt<=cnt-1.
  - sr<={ser_in, sr[WIDTH-1:1]} for LSB first, or {sr[WIDTH-2:0], ser_in} for MSB first.
- SHIFT state, consume with cnt==1 (last bit). Next word is chosen in priority order:
  - hb_full: sr<=hb, cnt<=WIDTH, stay in SHIFT. If accept happens in the same cycle it is impossible, because in_ready=0. hb_full<=0.
  - else if accept: sr<=in_data, cnt<=WIDTH, stay in SHIFT. This is the gapless pass-through path.
  - else: go to IDLE, cnt<=0. sr still updates with the final shift.
- SHIFT state, accept without a last-bit consume: hb<=in_data, hb_full<=1.
- SHIFT state, no consume (shift_en=0): sr, cnt and outputs hold; the bit is presented indefinitely.
- shift_en while in IDLE is ignored.
- word_done: registered, equal to (consume & cnt==1) from the previous cycle.
- Throughput:
  - With shift_en held high and in_valid held high, the block sustains one bit per clock across word boundaries.
  - Latency from first accept to first ser_valid is 1 cycle.
- After WIDTH consumes, par_out contains the WIDTH ser_in bits shifted in, which allows cascading blocks.

Test Plan:
- Reset: drive rst=0 mid-stream with hb_full=1 -> all outputs go to reset values immediately; after release, in_ready=1, ser_valid=0, and no word_done.
- Single word, LSB first: in_data=16'hA5C3, shift_en=1, ser_in=0 -> ser_out bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles; ser_first on bit 0, ser_last on bit 15; word_done one cycle later; then IDLE.
- Back-to-back: words 16'h0001, 16'h8000, 16'hFFFF with in_valid held high and shift_en=1 -> 48 consecutive ser_valid cycles with no gap; ser_first every 16 cycles; in_ready=0 while hb is full.
- Stall: deassert shift_en for 5 cycles at bit 7 of 16'h00F0 -> ser_out holds 1 and cnt holds 9; the word resumes and ends with correct bits and total length.
- MSB_FIRST=1, WIDTH=8: in_data=8'hB4, ser_in=1 -> ser_out 1,0,1,1,0,1,0,0; par_out=8'hFF after completion.
- clr asserted on a cycle with accept and the last bit consumed -> the block is empty next cycle (in_ready=1, busy=0), the accepted word is dropped, and no word_done.
